// File: rtl/core_pkg.sv
// Core-wide widths and the CDB / source-operand encodings shared by dispatch and the
// reservation stations.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned NUM_CDB = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cdb_t;

    // payload holds the value when rdy=1, otherwise the ROB tag in its low TAG_W bits
    typedef struct packed {
        logic            rdy;
        logic [XLEN-1:0] payload;
    } src_t;

endpackage

// File: rtl/rs_operand_slot.sv
// One source-operand capture register: holds a value or a pending ROB tag and snoops every CDB,
// including in the cycle it is written by dispatch.
module rs_operand_slot #(
    parameter int unsigned XLEN    = core_pkg::XLEN,
    parameter int unsigned TAG_W   = core_pkg::TAG_W,
    parameter int unsigned NUM_CDB = core_pkg::NUM_CDB
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic                            active,
    input  logic [XLEN:0]                   src,
    input  logic [NUM_CDB-1:0]              cdb_valid,
    input  logic [NUM_CDB*(TAG_W+XLEN)-1:0] cdb_bus,
    output logic                            rdy,
    output logic [XLEN-1:0]                 value
);

    localparam int unsigned BusW = TAG_W + XLEN;

    logic             rdy_q;
    logic [XLEN-1:0]  value_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] cmp_tag;
    logic             hit;
    logic [XLEN-1:0]  hit_data;

    // Walk buses from the top down so the lowest matching index is the one left standing.
    always_comb begin
        cmp_tag  = load ? src[TAG_W-1:0] : tag_q;
        hit      = 1'b0;
        hit_data = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (cdb_valid[b] && (cdb_bus[b*BusW+XLEN +: TAG_W] == cmp_tag)) begin
                hit      = 1'b1;
                hit_data = cdb_bus[b*BusW +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            value_q <= '0;
            tag_q   <= '0;
        end else if (load) begin
            tag_q <= src[TAG_W-1:0];
            if (src[XLEN]) begin
                rdy_q   <= 1'b1;
                value_q <= src[XLEN-1:0];
            end else if (hit) begin
                rdy_q   <= 1'b1;
                value_q <= hit_data;
            end else begin
                rdy_q <= 1'b0;
            end
        end else if (active && !rdy_q && hit) begin
            rdy_q   <= 1'b1;
            value_q <= hit_data;
        end
    end

    assign rdy   = rdy_q;
    assign value = value_q;

endmodule

// File: rtl/rs_operand_buffer.sv
// Reservation-station buffer: holds dispatched instructions until both operands are captured
// from the CDBs, then issues the oldest ready entry through a valid/ready handshake.
module rs_operand_buffer #(
    parameter int unsigned XLEN    = core_pkg::XLEN,
    parameter int unsigned TAG_W   = core_pkg::TAG_W,
    parameter int unsigned NUM_CDB = core_pkg::NUM_CDB,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned OP_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            disp_valid,
    output logic                            disp_ready,
    input  logic [OP_W-1:0]                 disp_op,
    input  logic [TAG_W-1:0]                disp_dst_tag,
    input  logic [XLEN:0]                   disp_src1,
    input  logic [XLEN:0]                   disp_src2,
    input  logic [NUM_CDB-1:0]              cdb_valid,
    input  logic [NUM_CDB*(TAG_W+XLEN)-1:0] cdb_bus,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [OP_W-1:0]                 issue_op,
    output logic [TAG_W-1:0]                issue_dst_tag,
    output logic [XLEN-1:0]                 issue_src1,
    output logic [XLEN-1:0]                 issue_src2,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DEPTH-1:0]  age_q, age_d;   // age_q[r][c]: entry r is older than c
    logic [CntW-1:0]              count_q, count_d;
    logic [OP_W-1:0]              op_q  [DEPTH];
    logic [TAG_W-1:0]             dst_q [DEPTH];

    logic [DEPTH-1:0] rdy1, rdy2, cand, sel, free_oh, load;
    logic [XLEN-1:0]  val1 [DEPTH];
    logic [XLEN-1:0]  val2 [DEPTH];
    logic             disp_fire, issue_fire, found;

    assign disp_ready = (count_q < CntW'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign issue_fire = issue_valid && issue_ready && !flush;
    assign count      = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign load[i] = disp_fire && free_oh[i];

        rs_operand_slot #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_src1 (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .active    (valid_q[i]),
            .src       (disp_src1),
            .cdb_valid (cdb_valid),
            .cdb_bus   (cdb_bus),
            .rdy       (rdy1[i]),
            .value     (val1[i])
        );

        rs_operand_slot #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_src2 (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .active    (valid_q[i]),
            .src       (disp_src2),
            .cdb_valid (cdb_valid),
            .cdb_bus   (cdb_bus),
            .rdy       (rdy2[i]),
            .value     (val2[i])
        );
    end

    // Lowest free entry; disp_ready guarantees one exists whenever dispatch fires.
    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // A candidate is selected when no other candidate is older than it.
    always_comb begin
        cand = valid_q & rdy1 & rdy2;
        sel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (cand[j] && age_q[j][i]) sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        issue_valid   = |cand;
        issue_op      = '0;
        issue_dst_tag = '0;
        issue_src1    = '0;
        issue_src2    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_op      |= {OP_W{sel[i]}} & op_q[i];
            issue_dst_tag |= {TAG_W{sel[i]}} & dst_q[i];
            issue_src1    |= {XLEN{sel[i]}} & val1[i];
            issue_src2    |= {XLEN{sel[i]}} & val2[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        count_d = count_q;
        if (issue_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel[i]) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = '0;
                    for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
                end
            end
        end
        if (disp_fire) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (free_oh[k]) begin
                    valid_d[k] = 1'b1;
                    age_d[k]   = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != k) age_d[j][k] = valid_d[j];
                    end
                end
            end
        end
        if (disp_fire && !issue_fire) count_d = count_q + CntW'(1);
        if (issue_fire && !disp_fire) count_d = count_q - CntW'(1);
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            age_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                dst_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    op_q[i]  <= disp_op;
                    dst_q[i] <= disp_dst_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_operand_buffer.sv
// Directed bench for rs_operand_buffer: wakeup, dispatch-cycle capture, age ordering,
// backpressure, full boundary, flush and asynchronous reset.
module tb_rs_operand_buffer;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned NUM_CDB = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned OP_W    = 8;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            flush;
    logic                            disp_valid;
    logic                            disp_ready;
    logic [OP_W-1:0]                 disp_op;
    logic [TAG_W-1:0]                disp_dst_tag;
    logic [XLEN:0]                   disp_src1;
    logic [XLEN:0]                   disp_src2;
    logic [NUM_CDB-1:0]              cdb_valid;
    logic [NUM_CDB*(TAG_W+XLEN)-1:0] cdb_bus;
    logic                            issue_valid;
    logic                            issue_ready;
    logic [OP_W-1:0]                 issue_op;
    logic [TAG_W-1:0]                issue_dst_tag;
    logic [XLEN-1:0]                 issue_src1;
    logic [XLEN-1:0]                 issue_src2;
    logic [$clog2(DEPTH+1)-1:0]      count;

    int checks   = 0;
    int failures = 0;

    core_pkg::cdb_t bus0, bus1, bus2;
    assign cdb_bus = {bus2, bus1, bus0};

    rs_operand_buffer #(
        .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .DEPTH(DEPTH), .OP_W(OP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_dst_tag  (disp_dst_tag),
        .disp_src1     (disp_src1),
        .disp_src2     (disp_src2),
        .cdb_valid     (cdb_valid),
        .cdb_bus       (cdb_bus),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_op      (issue_op),
        .issue_dst_tag (issue_dst_tag),
        .issue_src1    (issue_src1),
        .issue_src2    (issue_src2),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN:0] sval(input logic [XLEN-1:0] v);
        return {1'b1, v};
    endfunction

    function automatic logic [XLEN:0] stag(input logic [TAG_W-1:0] t);
        return {1'b0, {(XLEN-TAG_W){1'b0}}, t};
    endfunction

    task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dst,
                        input logic [XLEN:0] s1, input logic [XLEN:0] s2);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_dst_tag = dst;
        disp_src1    = s1;
        disp_src2    = s2;
    endtask

    task automatic cdb_idle();
        cdb_valid = '0;
        bus0 = '0;
        bus1 = '0;
        bus2 = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
        disp_op = '0; disp_dst_tag = '0; disp_src1 = '0; disp_src2 = '0;
        cdb_idle();
        #2;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_issue_valid", 64'(issue_valid), 64'd0);
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_issue_src1", 64'(issue_src1), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Wakeup latency: src1 pending on tag 5, CDB0 broadcast one cycle later.
        disp(8'h31, 6'd1, stag(6'd5), sval(32'h10));
        tick();
        disp_valid = 1'b0;
        chk("wake_count", 64'(count), 64'd1);
        chk("wake_pending", 64'(issue_valid), 64'd0);
        cdb_valid = 3'b001; bus0 = '{tag: 6'd5, data: 32'hAAAA0001};
        #1;
        chk("wake_same_cycle_no_issue", 64'(issue_valid), 64'd0);
        tick();
        cdb_idle();
        chk("wake_issue_valid", 64'(issue_valid), 64'd1);
        chk("wake_src1", 64'(issue_src1), 64'hAAAA0001);
        chk("wake_src2", 64'(issue_src2), 64'h10);
        chk("wake_op", 64'(issue_op), 64'h31);
        chk("wake_dst", 64'(issue_dst_tag), 64'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("wake_drained", 64'(count), 64'd0);
        chk("wake_drained_valid", 64'(issue_valid), 64'd0);

        // Dispatch-cycle capture with two buses matching: lowest bus index wins.
        disp(8'h42, 6'd2, stag(6'd9), sval(32'h5));
        cdb_valid = 3'b110;
        bus1 = '{tag: 6'd9, data: 32'h11};
        bus2 = '{tag: 6'd9, data: 32'h22};
        tick();
        disp_valid = 1'b0;
        cdb_idle();
        chk("capture_valid", 64'(issue_valid), 64'd1);
        chk("capture_src1", 64'(issue_src1), 64'h11);
        chk("capture_src2", 64'(issue_src2), 64'h5);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("capture_drained", 64'(count), 64'd0);

        // Oldest-first with backpressure, then reuse of a freed slot.
        disp(8'hA1, 6'd10, sval(32'h1), sval(32'h2)); tick();
        disp(8'hB2, 6'd11, sval(32'h3), sval(32'h4)); tick();
        disp(8'hC3, 6'd12, sval(32'h5), sval(32'h6)); tick();
        disp_valid = 1'b0;
        chk("order_count", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("order_hold_dst", 64'(issue_dst_tag), 64'd10);
            chk("order_hold_src1", 64'(issue_src1), 64'h1);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        chk("order_second", 64'(issue_dst_tag), 64'd11);
        disp(8'hD4, 6'd13, sval(32'h7), sval(32'h8));
        tick();
        disp_valid = 1'b0;
        chk("order_third", 64'(issue_dst_tag), 64'd12);
        chk("order_count_after_d", 64'(count), 64'd2);
        tick();
        chk("order_d_last", 64'(issue_dst_tag), 64'd13);
        chk("order_d_op", 64'(issue_op), 64'hD4);
        tick();
        issue_ready = 1'b0;
        chk("order_empty", 64'(count), 64'd0);

        // Full boundary: same-cycle issue does not free a slot for dispatch.
        for (int i = 0; i < 4; i++) begin
            disp(8'(i), 6'(20 + i), sval(32'(i)), sval(32'h0));
            tick();
        end
        disp_valid = 1'b0;
        chk("full_count", 64'(count), 64'd4);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        disp(8'hE0, 6'd24, sval(32'h99), sval(32'h0));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("full_count_after_issue", 64'(count), 64'd3);
        chk("full_ready_again", 64'(disp_ready), 64'd1);
        tick();
        disp_valid = 1'b0;
        chk("full_refill", 64'(count), 64'd4);
        issue_ready = 1'b1;
        chk("full_drain0", 64'(issue_dst_tag), 64'd21);
        tick();
        chk("full_drain1", 64'(issue_dst_tag), 64'd22);
        tick();
        chk("full_drain2", 64'(issue_dst_tag), 64'd23);
        tick();
        chk("full_drain3", 64'(issue_dst_tag), 64'd24);
        chk("full_drain3_src1", 64'(issue_src1), 64'h99);
        tick();
        issue_ready = 1'b0;
        chk("full_empty", 64'(count), 64'd0);

        // Flush wins over a same-cycle dispatch, wakeup and issue handshake.
        disp(8'h70, 6'd30, stag(6'd7), sval(32'h0)); tick();
        disp(8'h71, 6'd31, stag(6'd8), sval(32'h0)); tick();
        chk("flush_pre_count", 64'(count), 64'd2);
        disp(8'h72, 6'd32, sval(32'h3), sval(32'h0));
        cdb_valid = 3'b001; bus0 = '{tag: 6'd7, data: 32'h77};
        flush = 1'b1;
        issue_ready = 1'b1;
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        issue_ready = 1'b0;
        cdb_idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_issue_valid", 64'(issue_valid), 64'd0);
        tick();
        chk("flush_no_late_issue", 64'(issue_valid), 64'd0);
        disp(8'h73, 6'd33, stag(6'd7), sval(32'h0));
        tick();
        disp_valid = 1'b0;
        chk("flush_no_stale_wake", 64'(issue_valid), 64'd0);
        chk("flush_redispatch_count", 64'(count), 64'd1);
        cdb_valid = 3'b001; bus0 = '{tag: 6'd7, data: 32'h70};
        tick();
        cdb_idle();
        chk("flush_fresh_wake", 64'(issue_valid), 64'd1);
        chk("flush_fresh_src1", 64'(issue_src1), 64'h70);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) begin
            disp(8'h50, 6'(40 + i), sval(32'h1), sval(32'h1));
            tick();
        end
        disp_valid = 1'b0;
        chk("areset_pre_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_issue_valid", 64'(issue_valid), 64'd0);
        chk("areset_disp_ready", 64'(disp_ready), 64'd1);
        chk("areset_issue_dst", 64'(issue_dst_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_operand_buffer.md
Name: rs_operand_buffer

Overview:
- Parametrised reservation-station buffer; sits between the dispatch-stage source-operand select and the execution units of the out-of-order core.
- Holds up to DEPTH dispatched instructions whose source operands arrive either as values or as ROB tags.
- Snoops NUM_CDB common data buses every cycle to capture pending operands.
- Issues the oldest entry with both operands ready through a valid/ready handshake.

Parameters:
XLEN, 32, operand data width
TAG_W, 6, ROB tag width
NUM_CDB, 3, number of common data buses snooped
DEPTH, 4, number of buffer entries (2..16)
OP_W, 8, opaque opcode/control payload width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all entries
disp_valid  input  1  dispatch request
disp_ready  output  1  buffer can accept a dispatch this cycle
disp_op  input  OP_W  opcode payload
disp_dst_tag  input  TAG_W  destination ROB tag
disp_src1  input  XLEN+1  bit XLEN = ready; if ready, [XLEN-1:0] = value; else [TAG_W-1:0] = tag
disp_src2  input  XLEN+1  same encoding as disp_src1
cdb_valid  input  NUM_CDB  per-bus broadcast valid
cdb_bus  input  NUM_CDB*(TAG_W+XLEN)  bus i = {tag, data} at slice i
issue_valid  output  1  an entry is ready to issue
issue_ready  input  1  execution unit accepts
issue_op  output  OP_W  issued opcode
issue_dst_tag  output  TAG_W  issued destination tag
issue_src1  output  XLEN  operand 1 value
issue_src2  output  XLEN  operand 2 value
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - All entry valid bits and the age matrix clear.
  - count=0, issue_valid=0, disp_ready=1.
  - All issue_* data outputs 0.
- Per-entry state: valid, op, dst_tag, and per operand {rdy, value, tag}.
- Dispatch:
  - Fires when disp_valid && disp_ready.
  - Writes the lowest-index free entry.
  - disp_ready = (count < DEPTH), computed from registered state only; an issue in the same cycle does not free a slot for the same-cycle dispatch.
  - Dispatch-cycle capture: if a dispatched operand is not ready and its tag matches a valid CDB in the same cycle, the entry is written ready with the CDB data. This closes the broadcast/dispatch race.
- Wakeup:
  - Each cycle, every valid entry operand with rdy=0 compares its tag against all buses with cdb_valid=1.
  - On a match, the entry latches data and sets rdy=1 at the clock edge.
  - If several buses match, the lowest bus index wins.
  - Ready operands ignore the CDBs.
- Issue:
  - Candidates are valid entries with both rdy bits set in registered state. A CDB wakeup in cycle N allows issue no earlier than cycle N+1; dispatch in cycle N allows issue no earlier than N+1.
  - The oldest candidate, selected by a DEPTH x DEPTH age matrix, drives the issue_* outputs combinationally.
  - issue_valid = any candidate.
  - The entry is freed at the edge when issue_valid && issue_ready.
  - Outputs must stay stable while issue_valid && !issue_ready, unless an older entry becomes ready, which then takes over.
- Age matrix:
  - On dispatch into entry k, row k is set to older-than-nothing and column k marks k younger than all currently valid entries.
  - On free, the row and column of that entry clear.
- count: +1 on dispatch, -1 on issue; both in one cycle leaves it unchanged.
- Flush:
  - Has priority over dispatch and issue. At the edge, all valid bits clear and count=0.
  - issue_valid may be high in the flush cycle; the consumer must ignore it.
- Tags are compared at full TAG_W width. Tag 0 is not reserved; validity comes only from cdb_valid.

Decomposition:
- Shared package core_pkg holds XLEN, TAG_W, NUM_CDB, the cdb_t packed struct {tag, data}, and the src_t struct {rdy, payload} used by the operand-select stage.
- One natural sub-module, rs_operand_slot: a single operand's capture register with NUM_CDB-way tag compare, priority mux and dispatch-cycle capture. It is instantiated 2*DEPTH times.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst_n=0 asynchronously between edges -> count=0, issue_valid=0 and disp_ready=1 immediately, without waiting for a clock edge.
- Wakeup latency: dispatch {src1 tag 5 pending, src2 value 0x10}; cdb0 = {tag 5, 0xAAAA0001} in cycle 2 -> issue_valid=1 in cycle 3 with issue_src1=0xAAAA0001, issue_src2=0x10.
- Dispatch-cycle capture plus multi-bus conflict: dispatch src1 tag 9 while cdb1 and cdb2 both carry tag 9 (data 0x11, 0x22) -> entry captures 0x11 and issues next cycle.
- Oldest-first and backpressure:
  - Dispatch A, B, C, all ready. Hold issue_ready=0 for 3 cycles -> issue outputs stay A.
  - Release issue_ready -> issue order A, B, C.
  - Re-dispatch D into A's freed slot; D issues after C.
- Full boundary: fill DEPTH=4 -> disp_ready=0. Issue and dispatch both asserted in the same cycle -> dispatch not accepted, count 4->3; next cycle dispatch accepted, count=4.
- Flush: 2 pending entries plus dispatch and matching CDB in the same cycle as flush=1 -> count=0 next cycle, no later issue, and no stale wakeup on the following dispatch.
